mpmc11_wdf_sequencer: RTL and testbench
=======================================

// Module: mpmc11_wdf_sequencer
// PURPOSE
//  Sequences the MIG write-data FIFO (app_wdf_*) for one multi-strip write burst.
//  On start, streams strips 0..num_strips from the line buffer into app_wdf_data.
//  Drives app_wdf_wren/app_wdf_end with app_wdf_rdy back-pressure; end marks the final strip.
//  Sits between the mpmc11 write-path state machine and the MIG UI; it replaces ad-hoc wren/wend generation.
// PARAMETERS
//  DATA_WIDTH  128  width of one strip / app_wdf_data, bits (multiple of 8)
// PORTS
//  clk           in   1             system clock, all logic on rising edge
//  rst           in   1             synchronous active-high reset
//  start         in   1             begin burst; sampled only in IDLE
//  num_strips    in   6             index of last strip (strips = num_strips+1, 1..64)
//  strip_idx     out  6             index of strip the line buffer must present on strip_dat
//  strip_dat     in   DATA_WIDTH    line-buffer strip, combinational from strip_idx
//  strip_sel     in   DATA_WIDTH/8  byte enables for strip_dat (1 = write byte)
//  app_wdf_rdy   in   1             MIG write FIFO can accept
//  app_wdf_wren  out  1             write strobe
//  app_wdf_end   out  1             last strip of burst
//  app_wdf_data  out  DATA_WIDTH    write data
//  app_wdf_mask  out  DATA_WIDTH/8  byte mask = ~strip_sel (1 = masked)
//  strip_cnt     out  6             index of strip currently on app_wdf_data
//  busy          out  1             high in XFER and DONE
//  done          out  1             one-cycle pulse after last strip accepted
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE; wren, end, busy, done = 0;
//    data, mask, strip_idx, strip_cnt = 0. Reset mid-burst drops wren at the next edge.
//  - Accept = app_wdf_wren & app_wdf_rdy.
//  - States (mpmc11_wdf_seq_state_t): IDLE, XFER, DONE.
//  - IDLE: strip_idx=0. On start:
//    - latch num_strips into last_r;
//    - load data<=strip_dat, mask<=~strip_sel, strip_cnt<=0;
//    - wren<=1, end<=(num_strips==0), strip_idx<=1; go XFER.
//    - Latency: wren high the cycle after start.
//  - XFER, no accept: hold data, mask, wren, end, strip_cnt, strip_idx unchanged.
//  - XFER, accept with end=0:
//    - data<=strip_dat, mask<=~strip_sel, strip_cnt<=strip_idx, strip_idx<=strip_idx+1;
//    - end<=(strip_idx==last_r).
//    - With app_wdf_rdy held high: one strip per clock, no bubbles.
//  - XFER, accept with end=1: wren<=0, end<=0, done<=1; go DONE.
//  - DONE: done high exactly this cycle, strip_idx<=0; go IDLE. start in DONE is ignored.
//  - start while busy is ignored. num_strips changes after start have no effect.
//  - num_strips=0: single strip, wren and end rise together.
//  - num_strips=63: 64 strips. strip_idx wraps to 0 after the last load; the wrapped value is unused.
//  - app_wdf_end is never high without app_wdf_wren.
//  - Exactly num_strips+1 accepts occur per burst.
// STRUCTURE
//  - mpmc11_pkg: add typedef enum logic [1:0] mpmc11_wdf_seq_state_t {IDLE, XFER, DONE}.
//  - mpmc11_pkg: add localparam MPMC11_STRIP_BITS = 6.
//  - Single flat module; no sub-module. Counter and FSM fit in one always_ff plus next-state logic.
// TESTING
//  - Reset: rst=1 two cycles -> wren=end=busy=done=0, strip_idx=0.
//  - num_strips=3, rdy=1: start -> wren 4 consecutive cycles, strip_cnt 0,1,2,3;
//    end only on cycle 4; done pulses the next cycle.
//  - num_strips=0, rdy=1: start -> wren and end high the same single cycle;
//    data = strip 0; mask = ~strip_sel.
//  - num_strips=2, rdy low 3 cycles during strip 1: data, mask and end stay stable;
//    each strip is accepted exactly once; 3 accepts total.
//  - num_strips=63, rdy toggled randomly: exactly 64 accepts in order 0..63, then done;
//    start held high during the burst is ignored.
//  - rst asserted mid-burst at strip 5 of 8: next cycle wren=0, state IDLE;
//    a new start then begins again at strip 0.

Source files
------------

// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 memory-controller datapath.
// Holds the write-data-FIFO sequencer state encoding and strip index width.
package mpmc11_pkg;

  localparam int MPMC11_STRIP_BITS = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } mpmc11_wdf_seq_state_t;

endpackage : mpmc11_pkg

// File: rtl/mpmc11_wdf_sequencer.sv
// Streams one multi-strip write burst from the line buffer into the MIG write-data
// FIFO, honouring app_wdf_rdy back-pressure and flagging the final strip with app_wdf_end.
module mpmc11_wdf_sequencer
  import mpmc11_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [MPMC11_STRIP_BITS-1:0]  num_strips,
  output logic [MPMC11_STRIP_BITS-1:0]  strip_idx,
  input  logic [DATA_WIDTH-1:0]         strip_dat,
  input  logic [DATA_WIDTH/8-1:0]       strip_sel,
  input  logic                          app_wdf_rdy,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  output logic [DATA_WIDTH-1:0]         app_wdf_data,
  output logic [DATA_WIDTH/8-1:0]       app_wdf_mask,
  output logic [MPMC11_STRIP_BITS-1:0]  strip_cnt,
  output logic                          busy,
  output logic                          done
);

  mpmc11_wdf_seq_state_t state_q, state_d;

  logic [MPMC11_STRIP_BITS-1:0] last_q,      last_d;
  logic [MPMC11_STRIP_BITS-1:0] strip_idx_q, strip_idx_d;
  logic [MPMC11_STRIP_BITS-1:0] strip_cnt_q, strip_cnt_d;
  logic [DATA_WIDTH-1:0]        data_q,      data_d;
  logic [DATA_WIDTH/8-1:0]      mask_q,      mask_d;
  logic                         wren_q,      wren_d;
  logic                         end_q,       end_d;
  logic                         busy_q,      busy_d;
  logic                         done_q,      done_d;
  logic                         accept;

  assign accept = wren_q & app_wdf_rdy;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    strip_idx_d = strip_idx_q;
    strip_cnt_d = strip_cnt_q;
    data_d      = data_q;
    mask_d      = mask_q;
    wren_d      = wren_q;
    end_d       = end_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        strip_idx_d = '0;
        if (start) begin
          last_d      = num_strips;
          data_d      = strip_dat;
          mask_d      = ~strip_sel;
          strip_cnt_d = '0;
          wren_d      = 1'b1;
          end_d       = (num_strips == '0);
          strip_idx_d = MPMC11_STRIP_BITS'(1);
          state_d     = XFER;
        end
      end

      XFER: begin
        if (accept) begin
          if (end_q) begin
            wren_d  = 1'b0;
            end_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // strip_idx wraps to 0 after strip 63 is loaded; that value is never consumed
            data_d      = strip_dat;
            mask_d      = ~strip_sel;
            strip_cnt_d = strip_idx_q;
            strip_idx_d = strip_idx_q + MPMC11_STRIP_BITS'(1);
            end_d       = (strip_idx_q == last_q);
          end
        end
      end

      DONE: begin
        strip_idx_d = '0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
        wren_d  = 1'b0;
        end_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= '0;
      strip_idx_q <= '0;
      strip_cnt_q <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      wren_q      <= 1'b0;
      end_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      strip_idx_q <= strip_idx_d;
      strip_cnt_q <= strip_cnt_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      wren_q      <= wren_d;
      end_q       <= end_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign strip_idx    = strip_idx_q;
  assign strip_cnt    = strip_cnt_q;
  assign app_wdf_data = data_q;
  assign app_wdf_mask = mask_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = end_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule : mpmc11_wdf_sequencer

// File: tb/tb_mpmc11_wdf_sequencer.sv
// Directed bench for the write-data-FIFO sequencer: reset, burst lengths 1/3/4/64,
// back-pressure stability, start-while-busy and reset in the middle of a burst.
module tb_mpmc11_wdf_sequencer;

  localparam int DW = 128;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [5:0]    num_strips;
  logic [5:0]    strip_idx;
  logic [DW-1:0] strip_dat;
  logic [MW-1:0] strip_sel;
  logic          app_wdf_rdy;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic [5:0]    strip_cnt;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Line buffer model: each strip carries its own index so ordering is visible.
  function automatic logic [DW-1:0] pat(input logic [5:0] idx);
    return {4{24'hC0DE00, 2'b00, idx}};
  endfunction

  function automatic logic [MW-1:0] exp_mask(input logic [5:0] idx);
    return 16'h0001 << idx[3:0];
  endfunction

  assign strip_dat = pat(strip_idx);
  assign strip_sel = ~exp_mask(strip_idx);

  mpmc11_wdf_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_strips   (num_strips),
    .strip_idx    (strip_idx),
    .strip_dat    (strip_dat),
    .strip_sel    (strip_sel),
    .app_wdf_rdy  (app_wdf_rdy),
    .app_wdf_wren (app_wdf_wren),
    .app_wdf_end  (app_wdf_end),
    .app_wdf_data (app_wdf_data),
    .app_wdf_mask (app_wdf_mask),
    .strip_cnt    (strip_cnt),
    .busy         (busy),
    .done         (done)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_strips = '0; app_wdf_rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (app_wdf_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b exp=0", app_wdf_wren); end
    checks++; if (app_wdf_end !== 1'b0) begin errors++; $display("FAIL reset_end got=%b exp=0", app_wdf_end); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (strip_idx !== 6'd0) begin errors++; $display("FAIL reset_strip_idx got=%0d exp=0", strip_idx); end
    checks++; if (app_wdf_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", app_wdf_data); end
    rst = 1'b0;
    $display("reset: wren=%b end=%b busy=%b done=%b idx=%0d", app_wdf_wren, app_wdf_end, busy, done, strip_idx);
  endtask

  task automatic test_four_strips();
    @(negedge clk);
    num_strips = 6'd3; start = 1'b1; app_wdf_rdy = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++; if (app_wdf_wren !== (c <= 4)) begin errors++; $display("FAIL four_wren c=%0d got=%b exp=%b", c, app_wdf_wren, (c <= 4)); end
      checks++; if (app_wdf_end !== (c == 4)) begin errors++; $display("FAIL four_end c=%0d got=%b exp=%b", c, app_wdf_end, (c == 4)); end
      checks++; if (done !== (c == 5)) begin errors++; $display("FAIL four_done c=%0d got=%b exp=%b", c, done, (c == 5)); end
      checks++; if (busy !== (c <= 5)) begin errors++; $display("FAIL four_busy c=%0d got=%b exp=%b", c, busy, (c <= 5)); end
      if (c <= 4) begin
        checks++; if (strip_cnt !== 6'(c - 1)) begin errors++; $display("FAIL four_cnt c=%0d got=%0d exp=%0d", c, strip_cnt, c - 1); end
        checks++; if (app_wdf_data !== pat(6'(c - 1))) begin errors++; $display("FAIL four_data c=%0d got=%h exp=%h", c, app_wdf_data, pat(6'(c - 1))); end
        $display("four: strip %0d wren=%b end=%b", strip_cnt, app_wdf_wren, app_wdf_end);
      end
    end
  endtask

  task automatic test_single_strip();
    logic [DW-1:0] exp_d;
    logic [MW-1:0] exp_m;
    exp_d = {4{32'hC0DE0000}};
    exp_m = 16'h0001;
    @(negedge clk);
    num_strips = 6'd0; start = 1'b1; app_wdf_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (app_wdf_wren !== 1'b1) begin errors++; $display("FAIL single_wren got=%b exp=1", app_wdf_wren); end
    checks++; if (app_wdf_end !== 1'b1) begin errors++; $display("FAIL single_end got=%b exp=1", app_wdf_end); end
    checks++; if (app_wdf_data !== exp_d) begin errors++; $display("FAIL single_data got=%h exp=%h", app_wdf_data, exp_d); end
    checks++; if (app_wdf_mask !== exp_m) begin errors++; $display("FAIL single_mask got=%h exp=%h", app_wdf_mask, exp_m); end
    $display("single: strip %0d wren=%b end=%b mask=%h", strip_cnt, app_wdf_wren, app_wdf_end, app_wdf_mask);
    @(negedge clk);
    checks++; if (done !== 1'b1 || app_wdf_wren !== 1'b0) begin errors++; $display("FAIL single_done got done=%b wren=%b exp done=1 wren=0", done, app_wdf_wren); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_backpressure();
    int            accepts = 0;
    bit            seen_done = 0;
    logic [DW-1:0] held_d;
    logic [MW-1:0] held_m;
    logic          held_e;
    @(negedge clk);
    num_strips = 6'd2; start = 1'b1; app_wdf_rdy = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin seen_done = 1; break; end
      checks++; if (app_wdf_end && !app_wdf_wren) begin errors++; $display("FAIL bp_end_wo_wren c=%0d got end=1 wren=0", c); end
      if (c >= 3 && c <= 5) begin
        checks++; if (app_wdf_data !== held_d || app_wdf_mask !== held_m || app_wdf_end !== held_e || strip_cnt !== 6'd1)
          begin errors++; $display("FAIL bp_stable c=%0d got cnt=%0d end=%b data=%h exp cnt=1 end=%b data=%h", c, strip_cnt, app_wdf_end, app_wdf_data, held_e, held_d); end
      end
      held_d = app_wdf_data; held_m = app_wdf_mask; held_e = app_wdf_end;
      app_wdf_rdy = !(c >= 2 && c <= 4);
      if (app_wdf_wren && app_wdf_rdy) begin
        checks++; if (strip_cnt !== 6'(accepts) || app_wdf_data !== pat(6'(accepts)) || app_wdf_mask !== exp_mask(6'(accepts)) || app_wdf_end !== (accepts == 2))
          begin errors++; $display("FAIL bp_accept n=%0d got cnt=%0d end=%b exp cnt=%0d end=%b", accepts, strip_cnt, app_wdf_end, accepts, (accepts == 2)); end
        $display("bp: accept strip %0d at cycle %0d", strip_cnt, c);
        accepts++;
      end
    end
    checks++; if (!seen_done) begin errors++; $display("FAIL bp_timeout got done=0 exp done=1"); end
    checks++; if (accepts != 3) begin errors++; $display("FAIL bp_accepts got=%0d exp=3", accepts); end
    app_wdf_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_long_random();
    int accepts = 0;
    bit seen_done = 0;
    @(negedge clk);
    num_strips = 6'd63; start = 1'b1; app_wdf_rdy = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      num_strips = 6'd5;
      if (done) begin seen_done = 1; break; end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL long_busy c=%0d got=%b exp=1", c, busy); end
      checks++; if (app_wdf_end && !app_wdf_wren) begin errors++; $display("FAIL long_end_wo_wren c=%0d got end=1 wren=0", c); end
      app_wdf_rdy = 1'($urandom_range(0, 1));
      if (app_wdf_wren && app_wdf_rdy) begin
        checks++; if (strip_cnt !== 6'(accepts) || app_wdf_data !== pat(6'(accepts)) || app_wdf_end !== (accepts == 63))
          begin errors++; $display("FAIL long_accept n=%0d got cnt=%0d end=%b exp cnt=%0d end=%b", accepts, strip_cnt, app_wdf_end, accepts, (accepts == 63)); end
        $display("long: accept strip %0d", strip_cnt);
        accepts++;
      end
    end
    checks++; if (!seen_done) begin errors++; $display("FAIL long_timeout got done=0 exp done=1"); end
    checks++; if (accepts != 64) begin errors++; $display("FAIL long_accepts got=%0d exp=64", accepts); end
    @(negedge clk);
    checks++; if (app_wdf_wren !== 1'b0 || busy !== 1'b0 || strip_idx !== 6'd0)
      begin errors++; $display("FAIL long_start_in_done got wren=%b busy=%b idx=%0d exp 0 0 0", app_wdf_wren, busy, strip_idx); end
    start = 1'b0; app_wdf_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    bit hit = 0;
    num_strips = 6'd7; start = 1'b1; app_wdf_rdy = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (app_wdf_wren && strip_cnt == 6'd5) begin hit = 1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL midrst_reach got strip5=0 exp strip5=1"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0 || busy !== 1'b0 || strip_idx !== 6'd0)
      begin errors++; $display("FAIL midrst_clear got wren=%b end=%b busy=%b idx=%0d exp 0 0 0 0", app_wdf_wren, app_wdf_end, busy, strip_idx); end
    $display("midrst: reset at strip 5, wren=%b busy=%b", app_wdf_wren, busy);
    rst = 1'b0; num_strips = 6'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (app_wdf_wren !== 1'b1 || strip_cnt !== 6'd0 || app_wdf_data !== pat(6'd0) || app_wdf_end !== 1'b0)
      begin errors++; $display("FAIL midrst_restart got wren=%b cnt=%0d end=%b exp 1 0 0", app_wdf_wren, strip_cnt, app_wdf_end); end
    @(negedge clk);
    checks++; if (strip_cnt !== 6'd1 || app_wdf_end !== 1'b1 || app_wdf_data !== pat(6'd1))
      begin errors++; $display("FAIL midrst_second got cnt=%0d end=%b exp 1 1", strip_cnt, app_wdf_end); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done got=%b exp=1", done); end
    $display("midrst: restarted burst completed");
  endtask

  initial begin
    test_reset();
    test_four_strips();
    test_single_strip();
    test_backpressure();
    test_long_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mpmc11_wdf_sequencer
